ps2_digit_display: RTL and testbench

Captures PS/2 keyboard scancode bytes, decodes make codes for keys 0–9 into an NUM_DIGITS-deep shifting digit buffer, and drives a time-multiplexed common-anode 7-segment display. Sits between the PS/2 byte receiver and the board display pins. It is the multi-digit, break-code-aware successor to the single-digit combinational scancode-to-segment decoder.

---
 rtl/ps2_disp_pkg.sv | 49 ++++
 rtl/ps2_digit_display_seg_glyph_decode.sv | 27 ++
 rtl/ps2_digit_display.sv | 112 +++++++++++
 tb/tb_ps2_digit_display.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_disp_pkg.sv
// Shared types and constants for the PS/2 digit display: set-2 scancodes,
// glyph codes, prefix FSM states and the make-code to glyph lookup.
package ps2_disp_pkg;

   typedef logic [3:0] glyph_t;

   localparam glyph_t GLYPH_ERR   = 4'hE;
   localparam glyph_t GLYPH_BLANK = 4'hF;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_6     = 8'h36;
   localparam logic [7:0] SC_7     = 8'h3D;
   localparam logic [7:0] SC_8     = 8'h3E;
   localparam logic [7:0] SC_9     = 8'h46;
   localparam logic [7:0] SC_0     = 8'h45;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BREAK,
      ST_EXT,
      ST_EXT_BREAK
   } pfx_state_t;

   function automatic glyph_t scan_to_glyph(input logic [7:0] sc);
      glyph_t g;
      unique case (sc)
         SC_1:    g = 4'd1;
         SC_2:    g = 4'd2;
         SC_3:    g = 4'd3;
         SC_4:    g = 4'd4;
         SC_5:    g = 4'd5;
         SC_6:    g = 4'd6;
         SC_7:    g = 4'd7;
         SC_8:    g = 4'd8;
         SC_9:    g = 4'd9;
         SC_0:    g = 4'd0;
         default: g = GLYPH_ERR;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ps2_digit_display_seg_glyph_decode.sv
// Glyph code to active-low 7-segment pattern (seg[6:0] = g..a).
// Ports: glyph in (4b code), seg out (7b, 0 = lit).
module seg_glyph_decode
   import ps2_disp_pkg::*;
(
   input  glyph_t     glyph,
   output logic [6:0] seg
);

   always_comb begin
      unique case (glyph)
         4'd0:      seg = 7'b1000000;
         4'd1:      seg = 7'b1111001;
         4'd2:      seg = 7'b0100100;
         4'd3:      seg = 7'b0110000;
         4'd4:      seg = 7'b0011001;
         4'd5:      seg = 7'b0010010;
         4'd6:      seg = 7'b0000010;
         4'd7:      seg = 7'b1111000;
         4'd8:      seg = 7'b0000000;
         4'd9:      seg = 7'b0010000;
         GLYPH_ERR: seg = 7'b0000110;
         default:   seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/ps2_digit_display.sv
// PS/2 make-code capture into a shifting digit buffer, multiplexed onto a
// common-anode 7-seg display. Ports: clk, rst (async high), scan_valid,
// scan_code[7:0] in; seg[6:0], an[N-1:0] (active-low), digit_count out.
// Optional SCAN_BACKSPACE_EN: make code 0x66 deletes the newest digit.
module ps2_digit_display
   import ps2_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            scan_valid,
   input  logic [7:0]                      scan_code,
   output logic [6:0]                      seg,
   output logic [NUM_DIGITS-1:0]           an,
   output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int RW = $clog2(REFRESH_DIV);

   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

   pfx_state_t    state_q, state_d;
   glyph_t        ent_q [NUM_DIGITS];
   glyph_t        ent_d [NUM_DIGITS];
   logic [CW-1:0] count_q, count_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [IW-1:0] idx_q, idx_d;

   // Prefix tracking and buffer edits; entry 0 is the newest digit.
   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      count_d = count_q;
      if (scan_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_BREAK) begin
                  state_d = ST_BREAK;
               end else if (scan_code == SC_EXT) begin
                  state_d = ST_EXT;
`ifdef SCAN_BACKSPACE_EN
               end else if (scan_code == SC_BKSP) begin
                  if (count_q != '0) begin
                     for (int i = 0; i < NUM_DIGITS - 1; i++)
                        ent_d[i] = ent_q[i+1];
                     ent_d[NUM_DIGITS-1] = GLYPH_BLANK;
                     count_d = count_q - CW'(1);
                  end
`endif
               end else begin
                  for (int i = NUM_DIGITS - 1; i > 0; i--)
                     ent_d[i] = ent_q[i-1];
                  ent_d[0] = scan_to_glyph(scan_code);
                  if (count_q != CNT_FULL)
                     count_d = count_q + CW'(1);
               end
            end
            ST_BREAK:     state_d = ST_IDLE;
            ST_EXT:       state_d = (scan_code == SC_BREAK) ?
                                    ST_EXT_BREAK : ST_IDLE;
            ST_EXT_BREAK: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   // Digit slot rotation, independent of buffer edits.
   always_comb begin
      rcnt_d = rcnt_q + RW'(1);
      idx_d  = idx_q;
      if (rcnt_q == RCNT_LAST) begin
         rcnt_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < NUM_DIGITS; i++)
            ent_q[i] <= GLYPH_BLANK;
         count_q <= '0;
         rcnt_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         count_q <= count_d;
         rcnt_q  <= rcnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      an        = '1;
      an[idx_q] = 1'b0;
   end

   assign digit_count = count_q;

   seg_glyph_decode u_dec (
      .glyph (ent_q[idx_q]),
      .seg   (seg)
   );

endmodule

// File: tb/tb_ps2_digit_display.sv
// Directed bench for ps2_digit_display: reset/rotation, a cumulative byte
// table checked via digit_count and a full display frame, plus corner cases.
module tb_ps2_digit_display;

   localparam int N = 4;
   localparam int R = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scan_valid = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic [6:0] seg;
   logic [N-1:0] an;
   logic [2:0] digit_count;

   int total = 0;
   int bad = 0;

   logic [27:0] frame_got;
   bit          frame_oh;

   typedef struct {
      logic [7:0]  code;
      logic [15:0] ents;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs [17];

   ps2_digit_display #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scan_valid  (scan_valid),
      .scan_code   (scan_code),
      .seg         (seg),
      .an          (an),
      .digit_count (digit_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [6:0] exp_seg(input logic [3:0] g);
      logic [6:0] s;
      case (g)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'hE:    s = 7'b0000110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   function automatic logic [27:0] exp_frame(input logic [15:0] e);
      return {exp_seg(e[15:12]), exp_seg(e[11:8]),
              exp_seg(e[7:4]), exp_seg(e[3:0])};
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One full frame: capture the segments shown in each slot.
   task automatic read_frame();
      frame_oh  = 1'b1;
      frame_got = '0;
      for (int c = 0; c < N * R; c++) begin
         @(negedge clk);
         case (an)
            4'b1110: frame_got[6:0]   = seg;
            4'b1101: frame_got[13:7]  = seg;
            4'b1011: frame_got[20:14] = seg;
            4'b0111: frame_got[27:21] = seg;
            default: frame_oh = 1'b0;
         endcase
      end
   endtask

   task automatic check_state(input string name, input logic [15:0] ents,
                              input logic [2:0] cnt);
      check({name, "_cnt"}, 32'(digit_count), 32'(cnt));
      read_frame();
      check({name, "_frame"}, 32'(frame_got), 32'(exp_frame(ents)));
      check({name, "_onehot"}, 32'(frame_oh), 32'd1);
   endtask

   initial begin
      logic [3:0] exp_an [4];
      exp_an[0] = 4'b1101;
      exp_an[1] = 4'b1011;
      exp_an[2] = 4'b0111;
      exp_an[3] = 4'b1110;

      vecs[0]  = '{8'h16, 16'hFFF1, 3'd1};
      vecs[1]  = '{8'hF0, 16'hFFF1, 3'd1};
      vecs[2]  = '{8'h16, 16'hFFF1, 3'd1};
      vecs[3]  = '{8'h1E, 16'hFF12, 3'd2};
      vecs[4]  = '{8'hF0, 16'hFF12, 3'd2};
      vecs[5]  = '{8'h1E, 16'hFF12, 3'd2};
      vecs[6]  = '{8'hE0, 16'hFF12, 3'd2};
      vecs[7]  = '{8'h75, 16'hFF12, 3'd2};
      vecs[8]  = '{8'hE0, 16'hFF12, 3'd2};
      vecs[9]  = '{8'hF0, 16'hFF12, 3'd2};
      vecs[10] = '{8'h75, 16'hFF12, 3'd2};
      vecs[11] = '{8'h26, 16'hF123, 3'd3};
      vecs[12] = '{8'h25, 16'h1234, 3'd4};
      vecs[13] = '{8'h2E, 16'h2345, 3'd4};
      vecs[14] = '{8'h1C, 16'h345E, 3'd4};
`ifdef SCAN_BACKSPACE_EN
      vecs[15] = '{8'h66, 16'hF345, 3'd3};
      vecs[16] = '{8'h45, 16'h3450, 3'd4};
`else
      vecs[15] = '{8'h66, 16'h45EE, 3'd4};
      vecs[16] = '{8'h45, 16'h5EE0, 3'd4};
`endif

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_an", 32'(an), 32'b1110);
      check("rst_seg", 32'(seg), 32'b1111111);
      check("rst_cnt", 32'(digit_count), 32'd0);
      for (int k = 0; k < 4; k++) begin
         repeat (R) @(negedge clk);
         check($sformatf("rot_an%0d", k), 32'(an), 32'(exp_an[k]));
         check($sformatf("rot_seg%0d", k), 32'(seg), 32'b1111111);
      end

      for (int v = 0; v < 17; v++) begin
         send(vecs[v].code);
         check_state($sformatf("vec%0d", v), vecs[v].ents, vecs[v].cnt);
      end

      // Reset in the middle of a break prefix.
      pulse_rst();
      send(8'hF0);
      pulse_rst();
      send(8'h26);
      check_state("rst_mid_prefix", 16'hFFF3, 3'd1);

      // Backspace on an empty buffer.
      pulse_rst();
      send(8'h66);
`ifdef SCAN_BACKSPACE_EN
      check_state("bksp_empty", 16'hFFFF, 3'd0);
`else
      check_state("bksp_empty", 16'hFFFE, 3'd1);
`endif

      // Back-to-back strobes on consecutive cycles.
      pulse_rst();
      @(negedge clk);
      scan_valid = 1'b1;
      scan_code  = 8'h16;
      @(negedge clk);
      scan_code  = 8'h1E;
      @(negedge clk);
      scan_code  = 8'h26;
      @(negedge clk);
      scan_valid = 1'b0;
      check_state("b2b", 16'hF123, 3'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
